// File: rtl/wm_pkg.sv
// Shared types, program tables and BCD/segment helpers for the washing-machine sequencer.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } wm_state_e;

  localparam int PH_N   = 5;
  localparam int MODE_N = 4;

  // Indexed by wash_led bit: [4] soak, [3] wash, [2] rinse, [1] drain, [0] spin.
  localparam logic [5:0] PH_DUR [PH_N-1:0] = '{6'd15, 6'd9, 6'd6, 6'd3, 6'd3};

  localparam logic [PH_N-1:0] MODE_MASK [MODE_N] = '{5'b11111, 5'b01101, 5'b01111, 5'b00001};

  // Active-low segments, bit7 = a .. bit1 = g, bit0 = dp.
  localparam logic [7:0] SEG_LUT [10] = '{
    8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101, 8'b1001_1001,
    8'b0100_1001, 8'b0100_0001, 8'b0001_1111, 8'b0000_0001, 8'b0000_1001
  };

  function automatic logic [7:0] mask_total(input logic [PH_N-1:0] mask);
    logic [7:0] sum;
    sum = '0;
    for (int i = 0; i < PH_N; i++) begin
      if (mask[i]) sum = sum + 8'(PH_DUR[i]);
    end
    return sum;
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [7:0] v);
    logic [3:0] t;
    if      (v >= 8'd60) t = 4'd6;
    else if (v >= 8'd50) t = 4'd5;
    else if (v >= 8'd40) t = 4'd4;
    else if (v >= 8'd30) t = 4'd3;
    else if (v >= 8'd20) t = 4'd2;
    else if (v >= 8'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  function automatic logic [3:0] bcd_units(input logic [7:0] v);
    logic [7:0] u;
    u = v - (8'(bcd_tens(v)) * 8'd10);
    return u[3:0];
  endfunction

endpackage

// File: rtl/wm_seg_scan.sv
// Four-digit multiplexed 7-segment driver: total tens/units then remaining tens/units.
module wm_seg_scan
  import wm_pkg::*;
#(
  parameter int SCAN_CYCLES = 12_500,
  parameter int TIME_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_blank,
  input  logic [TIME_W-1:0] i_total,
  input  logic [TIME_W-1:0] i_rem,
  output logic [3:0]        o_an,
  output logic [7:0]        o_ag
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_digit;
  logic [7:0]        w_val;
  logic [3:0]        w_bcd;

  // Scan keeps running while blanked so the digit order never restarts mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_digit    <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    w_val = r_digit[1] ? 8'(i_rem) : 8'(i_total);
    w_bcd = r_digit[0] ? bcd_units(w_val) : bcd_tens(w_val);
    if (i_blank) begin
      o_an = 4'b1111;
      o_ag = 8'hFF;
    end else begin
      o_an = ~(4'b1000 >> r_digit);
      o_ag = SEG_LUT[w_bcd];
    end
  end

endmodule

// File: rtl/wash_ctrl_gen2.sv
// Washing-machine sequencer: power/pause/mode control, phase-masked programs, 1 s tick, auto power-off.
// Optional door interlock enabled by defining WM_DOOR_LOCK_EN.
module wash_ctrl_gen2
  import wm_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int SCAN_CYCLES = 12_500,
  parameter int NUM_PHASES  = 5,
  parameter int NUM_MODES   = 4,
  parameter int TIME_W      = 6,
  parameter int SHUTDOWN_S  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_pulse,
  input  logic                  pause_pulse,
  input  logic                  mode_pulse,
`ifdef WM_DOOR_LOCK_EN
  input  logic                  door_closed,
  output logic                  door_lock,
`endif
  output logic                  power_led,
  output logic                  pause_led,
  output logic                  auto_led,
  output logic [NUM_PHASES-1:0] wash_led,
  output logic                  done,
  output logic [3:0]            an,
  output logic [7:0]            ag
);

  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int SHUT_W = $clog2(SHUTDOWN_S + 1);
  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_CYCLES / 2);
  localparam logic [SHUT_W-1:0] SHUT_LAST = SHUT_W'(SHUTDOWN_S - 1);

  wm_state_e          r_state, w_state_nx;
  logic [MODE_W-1:0]  r_mode, w_mode_nx, w_mode_inc;
  logic [TIME_W-1:0]  r_rem, w_rem_nx;
  logic [TIME_W-1:0]  r_total, w_total_nx;
  logic [TICK_W-1:0]  r_tick_cnt, w_tick_nx;
  logic [SHUT_W-1:0]  r_shut_cnt, w_shut_nx;
  logic               r_done, w_done_nx;
  logic [TIME_W-1:0]  w_full, w_mode_tot;
  logic               w_tick, w_start_ok, w_door_open, w_powered;
  logic [PH_N-1:0]    w_mask, w_wash;

`ifdef WM_DOOR_LOCK_EN
  assign w_start_ok  = door_closed;
  assign w_door_open = ~door_closed;
  assign door_lock   = (r_state == ST_RUN);
`else
  assign w_start_ok  = 1'b1;
  assign w_door_open = 1'b0;
`endif

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_full     = TIME_W'(mask_total(MODE_MASK[0]));
  assign w_mode_inc = (r_mode == MODE_W'(NUM_MODES - 1)) ? '0 : r_mode + 1'b1;
  assign w_mode_tot = TIME_W'(mask_total(MODE_MASK[w_mode_inc]));
  assign w_mask     = MODE_MASK[r_mode];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_mode     <= '0;
      r_rem      <= TIME_W'(36);
      r_total    <= TIME_W'(36);
      r_tick_cnt <= '0;
      r_shut_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_mode     <= w_mode_nx;
      r_rem      <= w_rem_nx;
      r_total    <= w_total_nx;
      r_tick_cnt <= w_tick_nx;
      r_shut_cnt <= w_shut_nx;
      r_done     <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_rem_nx   = r_rem;
    w_total_nx = r_total;
    w_tick_nx  = r_tick_cnt;
    w_shut_nx  = r_shut_cnt;
    w_done_nx  = 1'b0;
    if (power_pulse) begin
      w_state_nx = (r_state == ST_OFF) ? ST_IDLE : ST_OFF;
      w_mode_nx  = '0;
      w_tick_nx  = '0;
      w_rem_nx   = w_full;
      w_total_nx = w_full;
    end else begin
      unique case (r_state)
        ST_OFF: ;
        ST_IDLE: begin
          if (pause_pulse) begin
            if (w_start_ok) begin
              w_state_nx = ST_RUN;
              w_tick_nx  = '0;
            end
          end else if (mode_pulse) begin
            w_mode_nx  = w_mode_inc;
            w_rem_nx   = w_mode_tot;
            w_total_nx = w_mode_tot;
          end
        end
        ST_RUN: begin
          if (pause_pulse || w_door_open) begin
            w_state_nx = ST_PAUSE;
          end else if (w_tick) begin
            w_tick_nx = '0;
            if (r_rem == TIME_W'(1)) begin
              w_rem_nx   = '0;
              w_state_nx = ST_DONE;
              w_done_nx  = 1'b1;
              w_shut_nx  = '0;
            end else begin
              w_rem_nx = r_rem - 1'b1;
            end
          end else begin
            w_tick_nx = r_tick_cnt + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (pause_pulse && w_start_ok) w_state_nx = ST_RUN;
        end
        ST_DONE: begin
          if (pause_pulse || mode_pulse) begin
            w_state_nx = ST_IDLE;
            w_mode_nx  = '0;
            w_rem_nx   = w_full;
            w_total_nx = w_full;
          end else if (w_tick) begin
            w_tick_nx = '0;
            if (r_shut_cnt == SHUT_LAST) begin
              w_state_nx = ST_OFF;
              w_mode_nx  = '0;
              w_rem_nx   = w_full;
              w_total_nx = w_full;
            end else begin
              w_shut_nx = r_shut_cnt + 1'b1;
            end
          end else begin
            w_tick_nx = r_tick_cnt + 1'b1;
          end
        end
        default: w_state_nx = ST_OFF;
      endcase
    end
  end

  // Walk phases soak->spin; the first one whose cumulative end lies beyond elapsed time is current.
  always_comb begin
    logic [7:0] cum;
    logic [7:0] elapsed;
    logic       found;
    cum     = '0;
    found   = 1'b0;
    w_wash  = '0;
    elapsed = 8'(r_total) - 8'(r_rem);
    for (int i = PH_N - 1; i >= 0; i--) begin
      if (w_mask[i]) begin
        cum = cum + 8'(PH_DUR[i]);
        if (cum > elapsed) begin
          if (!found) begin
            w_wash[i] = (r_state != ST_RUN) || (r_tick_cnt < TICK_HALF);
            found     = 1'b1;
          end else begin
            w_wash[i] = 1'b1;
          end
        end
      end
    end
    if (!(r_state inside {ST_IDLE, ST_RUN, ST_PAUSE})) w_wash = '0;
  end

  assign w_powered = (r_state != ST_OFF);
  assign power_led = w_powered;
  assign pause_led = w_powered && (r_state != ST_RUN);
  assign auto_led  = (r_state == ST_IDLE) && (r_mode == '0);
  assign wash_led  = NUM_PHASES'(w_wash);
  assign done      = r_done;

  wm_seg_scan #(
    .SCAN_CYCLES (SCAN_CYCLES),
    .TIME_W      (TIME_W)
  ) u_seg_scan (
    .clk     (clk),
    .rst     (rst),
    .i_blank (!w_powered),
    .i_total (r_total),
    .i_rem   (r_rem),
    .o_an    (an),
    .o_ag    (ag)
  );

endmodule

// File: tb/tb_wash_ctrl_gen2.sv
// Randomized and directed bench for wash_ctrl_gen2 against a program-level reference model.
module tb_wash_ctrl_gen2;

  localparam int TICK = 4;
  localparam int SCAN = 2;
  localparam int SHUT = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       power_pulse, pause_pulse, mode_pulse;
  logic       power_led, pause_led, auto_led, done;
  logic [4:0] wash_led;
  logic [3:0] an;
  logic [7:0] ag;

  always #5 clk = ~clk;

  wash_ctrl_gen2 #(
    .TICK_CYCLES (TICK),
    .SCAN_CYCLES (SCAN),
    .NUM_PHASES  (5),
    .NUM_MODES   (4),
    .TIME_W      (6),
    .SHUTDOWN_S  (SHUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .power_pulse (power_pulse),
    .pause_pulse (pause_pulse),
    .mode_pulse  (mode_pulse),
    .power_led   (power_led),
    .pause_led   (pause_led),
    .auto_led    (auto_led),
    .wash_led    (wash_led),
    .done        (done),
    .an          (an),
    .ag          (ag)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program position is the count of running cycles since start.
  typedef enum int {M_OFF, M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_e;
  mst_e m_st;
  int   m_mode, m_total, m_phase, m_dcyc, m_ncyc;
  bit   m_done;

  int         DUR  [5] = '{3, 3, 6, 9, 15};
  logic [4:0] MASK [4] = '{5'b11111, 5'b01101, 5'b01111, 5'b00001};
  logic [7:0] SEG  [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  function automatic int prog_len(input int mode);
    int s = 0;
    for (int b = 0; b < 5; b++) if (MASK[mode][b]) s += DUR[b];
    return s;
  endfunction

  task automatic model_reset();
    m_st = M_OFF; m_mode = 0; m_total = 36; m_phase = 0; m_dcyc = 0; m_ncyc = 0; m_done = 0;
  endtask

  task automatic model_step(input bit p, input bit s, input bit m);
    m_done = 0;
    if (p) begin
      m_st = (m_st == M_OFF) ? M_IDLE : M_OFF;
      m_mode = 0; m_total = 36; m_phase = 0;
    end else begin
      case (m_st)
        M_IDLE: if (s) begin m_st = M_RUN; m_phase = 0; end
                else if (m) begin m_mode = (m_mode + 1) % 4; m_total = prog_len(m_mode); end
        M_RUN: if (s) m_st = M_PAUSE;
               else begin
                 m_phase++;
                 if (m_phase == m_total * TICK) begin m_st = M_DONE; m_done = 1; m_dcyc = 0; end
               end
        M_PAUSE: if (s) m_st = M_RUN;
        M_DONE: if (s || m) begin m_st = M_IDLE; m_mode = 0; m_total = 36; end
                else begin
                  m_dcyc++;
                  if (m_dcyc == SHUT * TICK) begin m_st = M_OFF; m_mode = 0; m_total = 36; end
                end
        default: ;
      endcase
    end
    m_ncyc++;
  endtask

  function automatic int exp_rem();
    if (m_st == M_RUN || m_st == M_PAUSE) return m_total - m_phase / TICK;
    if (m_st == M_DONE) return 0;
    return m_total;
  endfunction

  function automatic logic [4:0] exp_wash();
    logic [4:0] w = '0;
    int el, cum;
    bit first;
    if (!(m_st == M_IDLE || m_st == M_RUN || m_st == M_PAUSE)) return '0;
    el = (m_st == M_IDLE) ? 0 : m_phase / TICK;
    cum = 0; first = 1;
    for (int b = 4; b >= 0; b--) begin
      if (MASK[m_mode][b]) begin
        cum += DUR[b];
        if (cum > el) begin
          w[b] = first ? ((m_st != M_RUN) || ((m_phase % TICK) < TICK / 2)) : 1'b1;
          first = 0;
        end
      end
    end
    return w;
  endfunction

  task automatic check_all();
    int dig, val, d;
    logic [3:0] ean;
    logic [7:0] eag;
    dig = (m_ncyc / SCAN) % 4;
    val = (dig < 2) ? m_total : exp_rem();
    d   = (dig % 2 == 0) ? val / 10 : val % 10;
    if (m_st == M_OFF) begin ean = 4'hF; eag = 8'hFF; end
    else begin ean = ~(4'b1000 >> dig); eag = SEG[d]; end
    check_val("power_led", power_led, m_st != M_OFF);
    check_val("pause_led", pause_led, (m_st != M_OFF) && (m_st != M_RUN));
    check_val("auto_led",  auto_led,  (m_st == M_IDLE) && (m_mode == 0));
    check_val("wash_led",  wash_led,  exp_wash());
    check_val("done",      done,      m_done);
    check_val("an",        an,        ean);
    check_val("ag",        ag,        eag);
  endtask

  // Starts and ends at a falling edge.
  task automatic step(input bit p, input bit s, input bit m);
    power_pulse = p; pause_pulse = s; mode_pulse = m;
    @(posedge clk);
    model_step(p, s, m);
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    power_pulse = 0; pause_pulse = 0; mode_pulse = 0;
    rst = 1'b1;
    model_reset();
    #1;
    check_val("rst_power_led", power_led, 0);
    check_val("rst_ag", ag, 8'hFF);
    check_val("rst_an", an, 4'hF);
    check_val("rst_rem", dut.r_rem, 36);
    check_val("rst_wash", wash_led, 0);
    check_val("rst_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; power_pulse = 0; pause_pulse = 0; mode_pulse = 0;
    #1;
    do_reset();

    step(1, 0, 0);
    step(0, 0, 1); step(0, 0, 1);
    check_val("mode2_wash", wash_led, 5'b01111);
    check_val("mode2_auto", auto_led, 0);
    check_val("mode2_rem", dut.r_rem, 21);
    step(0, 0, 1); step(0, 0, 1);
    check_val("mode0_auto", auto_led, 1);

    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    step(0, 1, 0);
    idle_steps(11);
    check_val("mode3_pre_done", done, 0);
    step(0, 0, 0);
    check_val("mode3_done", done, 1);
    idle_steps(79);
    check_val("shutdown_pre", power_led, 1);
    step(0, 0, 0);
    check_val("shutdown_off", power_led, 0);

    step(1, 0, 0); step(0, 1, 0);
    idle_steps(64);
    check_val("soak_done_wash", wash_led, 5'b01111);
    idle_steps(2);
    check_val("wash_blink_off", wash_led, 5'b00111);

    step(1, 0, 0); step(1, 0, 0); step(0, 1, 0);
    idle_steps(22);
    step(0, 1, 0);
    check_val("pause_rem", dut.r_rem, 31);
    idle_steps(40);
    check_val("paused_rem", dut.r_rem, 31);
    step(0, 1, 0);
    step(0, 0, 0);
    check_val("resume_rem_1", dut.r_rem, 31);
    step(0, 0, 0);
    check_val("resume_rem_2", dut.r_rem, 30);
    step(1, 1, 0);
    check_val("power_beats_pause", power_led, 0);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(299) == 0, $urandom_range(24) == 0, $urandom_range(9) == 0);
    end

    do_reset();
    step(1, 0, 0); step(0, 1, 0);
    idle_steps(10);
    do_reset();
    idle_steps(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
